// File: rtl/iotdf.sv
// ============================================================================
// iotdf -- IoT data filter.
//
// Collects 128-bit samples from an 8-bit byte stream, MSB byte first, and
// applies one of seven filter functions selected by fn_sel:
//   1 round max, 2 round min, 3 round average (8 samples per round),
//   4 range extract, 5 range exclude (per sample),
//   6 running peak max, 7 running peak min.
// Each result is registered and presented with a one-cycle valid pulse.
//
// Optional feature macro: IOTDF_PEAK_EN
//   defined   -> fn 6 / fn 7 peak tracking is built in.
//   undefined -> peak registers are omitted; fn 6 / fn 7 consume bytes
//                but never assert valid (same as fn 0).
// ============================================================================
module iotdf #(
    parameter logic [127:0] LOW_EXT  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] HIGH_EXT = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] LOW_EXC  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] HIGH_EXC = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_en,
    input  logic [7:0]   iot_in,
    input  logic [2:0]   fn_sel,
    output logic         busy,
    output logic         valid,
    output logic [127:0] iot_out
);

    // Function codes
    localparam logic [2:0] FN_MAX  = 3'd1;
    localparam logic [2:0] FN_MIN  = 3'd2;
    localparam logic [2:0] FN_AVG  = 3'd3;
    localparam logic [2:0] FN_EXT  = 3'd4;
    localparam logic [2:0] FN_EXC  = 3'd5;
`ifdef IOTDF_PEAK_EN
    localparam logic [2:0] FN_PMAX = 3'd6;
    localparam logic [2:0] FN_PMIN = 3'd7;
`endif

    // ------------------------------------------------------------------
    // Capture state: partial sample shift register and counters
    // ------------------------------------------------------------------
    logic [3:0]   byte_cnt;
    logic [2:0]   samp_cnt;
    logic [127:0] sample_p0;

    // Round state: running max/min and the wide sum
    logic [127:0] round_max;
    logic [127:0] round_min;
    logic [130:0] acc;

    // Combinational view of the sample completing this cycle
    logic [127:0] new_sample;
    logic         sample_done;
    logic         round_first;
    logic         round_last;
    logic [127:0] cur_max;
    logic [127:0] cur_min;
    logic [130:0] cur_sum;

    // Result selection
    logic         emit;
    logic [127:0] result;

    // The design never stalls the source.
    assign busy = 1'b0;

`ifdef IOTDF_PEAK_EN
    logic [127:0] peak_max;
    logic [127:0] peak_min;
    logic         peak_max_set;
    logic         peak_min_set;
    logic         peak_max_upd;
    logic         peak_min_upd;
`endif

    // Sample-completion detection and the round max/min/sum including the current sample
    always_comb begin
        new_sample  = {sample_p0[119:0], iot_in};
        sample_done = in_en && !busy && (byte_cnt == 4'd15);
        round_first = (samp_cnt == 3'd0);
        round_last  = (samp_cnt == 3'd7);
        // First sample of a round loads directly so stale values never leak in.
        cur_max     = (round_first || (new_sample > round_max)) ? new_sample : round_max;
        cur_min     = (round_first || (new_sample < round_min)) ? new_sample : round_min;
        cur_sum     = acc + {3'b000, new_sample};
    end

`ifdef IOTDF_PEAK_EN
    // Peak update decisions at round end; first round always records a peak
    always_comb begin
        peak_max_upd = sample_done && round_last && (fn_sel == FN_PMAX) &&
                       (!peak_max_set || (cur_max > peak_max));
        peak_min_upd = sample_done && round_last && (fn_sel == FN_PMIN) &&
                       (!peak_min_set || (cur_min < peak_min));
    end
`endif

    // Function mux: decides whether this cycle produces a result and which value
    always_comb begin
        emit   = 1'b0;
        result = new_sample;
        case (fn_sel)
            FN_MAX: begin
                emit   = sample_done && round_last;
                result = cur_max;
            end
            FN_MIN: begin
                emit   = sample_done && round_last;
                result = cur_min;
            end
            FN_AVG: begin
                emit   = sample_done && round_last;
                result = cur_sum[130:3];
            end
            FN_EXT: begin
                emit   = sample_done && (new_sample > LOW_EXT) && (new_sample < HIGH_EXT);
                result = new_sample;
            end
            FN_EXC: begin
                emit   = sample_done && ((new_sample < LOW_EXC) || (new_sample > HIGH_EXC));
                result = new_sample;
            end
`ifdef IOTDF_PEAK_EN
            FN_PMAX: begin
                emit   = peak_max_upd;
                result = cur_max;
            end
            FN_PMIN: begin
                emit   = peak_min_upd;
                result = cur_min;
            end
`endif
            default: begin
                emit   = 1'b0;
                result = new_sample;
            end
        endcase
    end

    // --- stage p0: byte capture into the sample shift register ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= 4'd0;
            sample_p0 <= 128'd0;
        end else if (in_en && !busy) begin
            sample_p0 <= new_sample;
            byte_cnt  <= byte_cnt + 4'd1;
        end
    end

    // Round bookkeeping: sample counter, running max/min and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt  <= 3'd0;
            round_max <= 128'd0;
            round_min <= 128'd0;
            acc       <= 131'd0;
        end else if (sample_done) begin
            samp_cnt  <= samp_cnt + 3'd1;
            round_max <= cur_max;
            round_min <= cur_min;
            acc       <= round_last ? 131'd0 : cur_sum;
        end
    end

`ifdef IOTDF_PEAK_EN
    // Peak registers and their initialised flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_max     <= 128'd0;
            peak_min     <= 128'd0;
            peak_max_set <= 1'b0;
            peak_min_set <= 1'b0;
        end else begin
            if (peak_max_upd) begin
                peak_max     <= cur_max;
                peak_max_set <= 1'b1;
            end
            if (peak_min_upd) begin
                peak_min     <= cur_min;
                peak_min_set <= 1'b1;
            end
        end
    end
`endif

    // --- stage p1: registered result with one-cycle valid pulse ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            iot_out <= 128'd0;
        end else begin
            valid <= emit;
            if (emit) begin
                iot_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_iotdf.sv
// ============================================================================
// tb_iotdf -- self-checking bench for iotdf.
// Drives directed and $urandom sample streams and compares valid/iot_out
// every cycle against a queue-based reference model of the filter rules.
// Peak expectations follow IOTDF_PEAK_EN the same way the design does.
// ============================================================================
module tb_iotdf;

    localparam logic [127:0] LOW_EXT  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] HIGH_EXT = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] LOW_EXC  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] HIGH_EXC = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] ONES     = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         busy;
    logic         valid;
    logic [127:0] iot_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [127:0] round_q[$];
    logic         pmax_set, pmin_set;
    logic [127:0] pmax, pmin;
    logic         exp_vld;
    logic [127:0] exp_out;
    bit           gaps;

    iotdf dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .iot_in  (iot_in),
        .fn_sel  (fn_sel),
        .busy    (busy),
        .valid   (valid),
        .iot_out (iot_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        round_q.delete();
        pmax_set = 1'b0;
        pmin_set = 1'b0;
        pmax     = '0;
        pmin     = '0;
        exp_vld  = 1'b0;
        exp_out  = '0;
    endtask

    task automatic emit(input logic [127:0] v);
        exp_vld = 1'b1;
        exp_out = v;
    endtask

    // Apply the filter rules to one completed sample
    task automatic model_sample(input logic [127:0] s);
        logic [127:0] mx, mn;
        logic [130:0] sum;
        if (fn_sel == 3'd4 && s > LOW_EXT && s < HIGH_EXT) emit(s);
        if (fn_sel == 3'd5 && (s < LOW_EXC || s > HIGH_EXC)) emit(s);
        round_q.push_back(s);
        if (round_q.size() == 8) begin
            mx  = round_q[0];
            mn  = round_q[0];
            sum = '0;
            foreach (round_q[i]) begin
                if (round_q[i] > mx) mx = round_q[i];
                if (round_q[i] < mn) mn = round_q[i];
                sum = sum + 131'(round_q[i]);
            end
            case (fn_sel)
                3'd1: emit(mx);
                3'd2: emit(mn);
                3'd3: emit(sum[130:3]);
`ifdef IOTDF_PEAK_EN
                3'd6: if (!pmax_set || mx > pmax) begin pmax = mx; pmax_set = 1'b1; emit(mx); end
                3'd7: if (!pmin_set || mn < pmin) begin pmin = mn; pmin_set = 1'b1; emit(mn); end
`endif
                default: ;
            endcase
            round_q.delete();
        end
    endtask

    // One cycle: compare outputs at the falling edge, then retire the pulse
    task automatic tick_check();
        @(negedge clk);
        chk("valid", 128'(valid), 128'(exp_vld));
        chk("iot_out", iot_out, exp_out);
        chk("busy", 128'(busy), 128'd0);
        exp_vld = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick_check();
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_en = 1'b0;
            tick_check();
        end
        in_en  = 1'b1;
        iot_in = b;
    endtask

    task automatic send_sample(input logic [127:0] s);
        for (int i = 0; i < 16; i++) send_byte(s[127 - 8*i -: 8]);
        model_sample(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick_check();
            in_en = 1'b0;
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once
    task automatic do_reset(input logic [2:0] fn);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_iot_out", iot_out, 128'd0);
        model_reset();
        in_en  = 1'b0;
        fn_sel = fn;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_rounds(input int n);
        for (int i = 0; i < 8 * n; i++) send_sample(rand128());
    endtask

    task automatic range_samples(input int n);
        logic [127:0] s;
        for (int i = 0; i < n; i++) begin
            s = rand128();
            s[127:120] = 8'($urandom_range(8'h60, 8'hC5));
            if ($urandom_range(0, 4) == 0) s[119:0] = {120{s[0]}};
            send_sample(s);
        end
    endtask

    task automatic peak_max_round(input logic [127:0] m);
        for (int i = 0; i < 7; i++) send_sample(128'($urandom_range(0, 32'(m))));
        send_sample(m);
    endtask

    task automatic peak_min_round(input logic [127:0] m);
        send_sample(m);
        for (int i = 0; i < 7; i++) send_sample(m + 128'($urandom_range(0, 50)));
    endtask

    initial begin
        rst    = 1'b0;
        in_en  = 1'b0;
        iot_in = 8'h00;
        fn_sel = 3'd1;
        gaps   = 1'b0;
        model_reset();

        // Partial sample, then reset mid-sample; 1..8 must still yield max 8
        do_reset(3'd1);
        for (int i = 0; i < 5; i++) send_byte(8'hA5);
        do_reset(3'd1);
        for (int i = 1; i <= 8; i++) send_sample(128'(i));
        idle(2);
        rand_rounds(2);
        gaps = 1'b1;
        rand_rounds(1);
        idle(2);
        gaps = 1'b0;

        // Min
        do_reset(3'd2);
        for (int i = 1; i <= 8; i++) send_sample(128'(i));
        rand_rounds(2);
        idle(2);

        // Average, including the all-ones overflow case
        do_reset(3'd3);
        for (int i = 1; i <= 8; i++) send_sample(128'(i));
        for (int i = 0; i < 8; i++) send_sample(ONES);
        gaps = 1'b1;
        rand_rounds(2);
        gaps = 1'b0;
        idle(2);

        // Extract: boundaries then biased random samples
        do_reset(3'd4);
        send_sample(LOW_EXT);
        send_sample(128'h7000_0000_0000_0000_0000_0000_0000_0000);
        send_sample(HIGH_EXT);
        range_samples(16);
        idle(2);

        // Exclude
        do_reset(3'd5);
        send_sample(LOW_EXC);
        send_sample(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send_sample(128'hC000_0000_0000_0000_0000_0000_0000_0000);
        send_sample(HIGH_EXC);
        gaps = 1'b1;
        range_samples(16);
        gaps = 1'b0;
        idle(2);

        // Peak max: rounds with max 5, 3, 5, 9
        do_reset(3'd6);
        peak_max_round(128'd5);
        peak_max_round(128'd3);
        peak_max_round(128'd5);
        peak_max_round(128'd9);
        rand_rounds(2);
        idle(2);

        // Peak min: rounds with min 5, 7, 2, 2
        do_reset(3'd7);
        peak_min_round(128'd5);
        peak_min_round(128'd7);
        peak_min_round(128'd2);
        peak_min_round(128'd2);
        idle(2);

        // fn 0: bytes consumed, never a result
        do_reset(3'd0);
        rand_rounds(1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iotdf.md
Name: iotdf

Overview:
- IoT data filter. Receives 128-bit samples serially as 16 bytes, MSB byte first, on an 8-bit bus.
- Applies one of seven functions selected by fn_sel:
  - round-based max, min or average over each group of 8 samples
  - per-sample range extract or range exclude
  - running peak max or peak min
- Presents each 128-bit result with a one-cycle valid pulse.
- Sits between a sensor byte stream and a downstream result consumer.

Parameters:
- LOW_EXT, 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, lower bound for fn 4.
- HIGH_EXT, 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, upper bound for fn 4.
- LOW_EXC, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, lower bound for fn 5.
- HIGH_EXC, 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, upper bound for fn 5.

Ports:
- clk  in  1  clock; single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_en  in  1  iot_in byte valid this cycle
- iot_in  in  8  data byte; byte 0 of a sample is bits [127:120]
- fn_sel  in  3  function select 1..7; static during operation
- busy  out  1  DUT cannot accept bytes; source must hold in_en low
- valid  out  1  one-cycle pulse, iot_out holds a result
- iot_out  out  128  result data

Behaviour:
- Reset values: busy=0, valid=0, iot_out=0.
- Reset also clears the byte counter (0..15), sample counter (0..7), accumulator, round max/min and peak registers, and the peak-initialised flag.
- Reset mid-sample discards the partial sample and the partial round.
- Byte capture: a byte is accepted on a rising edge where in_en=1 and busy=0. It is shifted in as sample = {sample[119:0], iot_in}.
- The 16th accepted byte completes a sample and is the sample-complete event; the byte counter wraps to 0. Gaps (in_en=0) between bytes are allowed.
- busy stays 0 after reset. The design accepts a byte every cycle with no stalls.
- Latency: valid rises the cycle after the completing byte's clock edge, i.e. the result is registered. valid stays high exactly 1 cycle. iot_out holds its last value when valid=0.
- Round: 8 consecutive samples. The sample counter wraps 7->0 at round end.
- fn 1 Max: at round end, output the unsigned maximum of the 8 samples.
- fn 2 Min: at round end, output the unsigned minimum.
- fn 3 Avg:
  - a 131-bit accumulator sums the 8 samples
  - output is sum>>3, truncated
  - the accumulator clears at round end
- fn 4 Extract: per sample, output the sample if LOW_EXT < s < HIGH_EXT (strict, unsigned). Otherwise no valid.
- fn 5 Exclude: per sample, output the sample if s < LOW_EXC or s > HIGH_EXC (strict). Otherwise no valid.
- fn 6 Peak Max: at round end, compute the round max.
  - If no peak has been recorded yet, or round max > peak, update peak and output it.
  - Otherwise (including equal) no valid.
- fn 7 Peak Min: same as fn 6 using the round min and "<".
- fn 0: no outputs. Bytes are still consumed.
- The round max/min registers load the first sample of each round directly, not compared against stale values.
- Bytes arriving in the cycle a result is emitted are accepted normally. Result emission never blocks input.

Optional Feature:
- Macro IOTDF_PEAK_EN.
- Defined: fn 6 and fn 7 are implemented as above.
- Undefined: peak registers and peak logic are omitted. fn_sel 6/7 behave like fn 0: bytes consumed, valid never asserted.

Test Plan:
- Reset: assert rst asynchronously mid-sample -> busy=0, valid=0, iot_out=0 immediately. The next 16 bytes form a fresh sample.
- fn 1 with 8 samples 1..8 (16 bytes each, back-to-back) -> exactly one valid, 1 cycle after the last byte, iot_out=8.
- fn 2 and fn 3 with samples 1..8 -> fn 2 outputs 1; fn 3 outputs (36>>3)=4.
- fn 3 overflow: 8 samples of all-ones -> output 128'hFFFF..FF, from a 131-bit sum with no wrap.
- fn 4 with samples 6FFF..FF, 7000..00, AFFF..FF -> a single valid, with 7000..00. Then fn 5 with 7FFF..FF, 8000..00, C000..00 -> valids for C000..00 only (7FFF..FF is not strictly below LOW_EXC).
- fn 6 over rounds with max 5, 3, 5, 9 -> outputs 5 and 9 only. fn 7 with min 5, 7, 2, 2 -> outputs 5 and 2 once.
